// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-stream program loader: FSM encoding,
// stream framing sizes and the checksum width.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_WRITE,
        ST_CHECK,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam int LEN_BYTES  = 2;
    localparam int WORD_BYTES = 4;
    localparam int CSUM_W     = 8;

    // Word-aligned byte address of word idx; wraps naturally at 32 bits.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [29:0] idx);
        return base + {idx, 2'b00};
    endfunction

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Collects stream bytes big-endian into one word and flags the byte that
// completes it.
module word_assembler
    import prog_loader_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_clr,
    input  logic                      i_shift,
    input  logic [7:0]                i_byte,
    output logic [8*WORD_BYTES-1:0]   o_word,
    output logic                      o_complete
);

    localparam int CNT_W = $clog2(WORD_BYTES);

    logic [CNT_W-1:0]        r_cnt;
    logic [8*WORD_BYTES-1:0] r_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (i_clr) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (i_shift) begin
            r_cnt   <= r_cnt + 1'b1;
            r_shift <= o_word;
        end
    end

    // o_word already includes the incoming byte so the caller can capture
    // the finished word on the same edge as the last transfer.
    assign o_word     = {r_shift[8*WORD_BYTES-9:0], i_byte};
    assign o_complete = i_shift && (r_cnt == CNT_W'(WORD_BYTES - 1));

endmodule

// File: rtl/prog_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction
// memory and releases the processor reset only after a clean load.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [8*LEN_BYTES-1:0] MAX_W = (8*LEN_BYTES)'(MAX_WORDS);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [8*LEN_BYTES-1:0]  r_len;
    logic [29:0]             r_index;
    logic [CSUM_W-1:0]       r_csum;
    logic [31:0]             r_mem_addr;
    logic [31:0]             r_mem_wdata;

    logic                    w_ready;
    logic                    w_xfer;
    logic                    w_start_ok;
    logic [8*LEN_BYTES-1:0]  w_len_full;
    logic                    w_len_bad;
    logic [29:0]             w_idx_inc;
    logic                    w_more;
    logic [31:0]             w_word;
    logic                    w_word_done;

    assign w_ready    = (r_state == ST_LEN_HI) || (r_state == ST_LEN_LO) ||
                        (r_state == ST_DATA)   || (r_state == ST_CHECK);
    assign w_xfer     = byte_valid && w_ready;
    assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                  (r_state == ST_ERR));
    assign w_len_full = {r_len[15:8], byte_data};
    assign w_len_bad  = (w_len_full == '0) || (w_len_full > MAX_W);
    assign w_idx_inc  = r_index + 30'd1;
    assign w_more     = w_idx_inc < {14'd0, r_len};

    word_assembler u_word_assembler (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_start_ok),
        .i_shift    ((r_state == ST_DATA) && w_xfer),
        .i_byte     (byte_data),
        .o_word     (w_word),
        .o_complete (w_word_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: if (start) w_state_next = ST_LEN_HI;
            ST_LEN_HI: if (w_xfer) w_state_next = ST_LEN_LO;
            ST_LEN_LO: if (w_xfer) w_state_next = w_len_bad ? ST_ERR : ST_DATA;
            ST_DATA:   if (w_word_done) w_state_next = ST_WRITE;
            ST_WRITE:  w_state_next = w_more ? ST_DATA : ST_CHECK;
            ST_CHECK:  if (w_xfer) w_state_next = (byte_data == r_csum) ? ST_DONE : ST_ERR;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len       <= '0;
            r_index     <= '0;
            r_csum      <= '0;
            r_mem_addr  <= BASE_ADDR;
            r_mem_wdata <= '0;
        end else begin
            if (w_start_ok) begin
                r_index <= '0;
                r_csum  <= '0;
            end
            if ((r_state == ST_LEN_HI) && w_xfer) r_len[15:8] <= byte_data;
            if ((r_state == ST_LEN_LO) && w_xfer) r_len[7:0]  <= byte_data;
            if ((r_state == ST_DATA) && w_xfer)   r_csum      <= r_csum ^ byte_data;
            // Address and data are staged on the last byte so they are stable
            // for the whole WRITE cycle and held afterwards.
            if (w_word_done) begin
                r_mem_addr  <= word_addr(BASE_ADDR, r_index);
                r_mem_wdata <= w_word;
            end
            if (r_state == ST_WRITE) r_index <= w_idx_inc;
        end
    end

    assign byte_ready = w_ready;
    assign mem_we     = (r_state == ST_WRITE);
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign busy       = w_ready || (r_state == ST_WRITE);
    assign done       = (r_state == ST_DONE);
    assign err        = (r_state == ST_ERR);
    assign cpu_rst    = (r_state != ST_DONE);

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: stimulus pushes expected memory writes into
// a queue and a negedge monitor pops and compares each write it observes.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    prog_loader #(
        .BASE_ADDR (32'h0000_0000),
        .MAX_WORDS (256)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];
    logic [7:0]  stim_q[$];
    logic [7:0]  hold_q[$];

    // Two-word reference stream (length 2); its payload XOR is 0x0E.
    logic [7:0]  ref_stream [0:9] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                                      8'h20, 8'h09, 8'h00, 8'h0A};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic push_stream(input logic [7:0] cs);
        foreach (ref_stream[i]) stim_q.push_back(ref_stream[i]);
        stim_q.push_back(cs);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Sends every queued byte; each wait for byte_ready is bounded.
    task automatic send_q(input bit gaps);
        int budget;
        while (stim_q.size() > 0) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    byte_valid = 1'b0;
                    byte_data  = 8'($urandom);
                    @(negedge clk);
                end
            end
            byte_valid = 1'b1;
            byte_data  = stim_q.pop_front();
            budget     = 0;
            while (!byte_ready && budget < 20) begin
                @(negedge clk);
                budget++;
            end
            if (!byte_ready) begin
                n_checks++;
                n_fail++;
                $display("FAIL ready_timeout: byte_ready stayed 0 for 20 cycles, required 1");
                stim_q.delete();
            end else begin
                @(negedge clk);
            end
            byte_valid = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst && mem_we) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, required no write",
                         mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", mem_addr, e[63:32]);
                chk("wr_data", mem_wdata, e[31:0]);
                $display("write addr=0x%08h data=0x%08h", mem_addr, mem_wdata);
            end
            chk1("ready_in_write", byte_ready, 1'b0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  cs;
        logic [7:0]  b;
        logic [31:0] w;

        rst        = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (3) @(negedge clk);

        chk1("rst_cpu_rst", cpu_rst, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_ready", byte_ready, 1'b0);
        chk1("rst_we", mem_we, 1'b0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Good two-word load.
        expect_wr(32'h0, 32'h2008_0005);
        expect_wr(32'h4, 32'h2009_000A);
        pulse_start();
        push_stream(8'h0E);
        send_q(1'b0);
        chk1("good_done", done, 1'b1);
        chk1("good_err", err, 1'b0);
        chk1("good_cpu_rst", cpu_rst, 1'b0);
        chk1("good_busy", busy, 1'b0);
        $display("session good: done=%0b err=%0b cpu_rst=%0b", done, err, cpu_rst);

        // Wrong checksum 0x00: words still written, session fails.
        expect_wr(32'h0, 32'h2008_0005);
        expect_wr(32'h4, 32'h2009_000A);
        pulse_start();
        push_stream(8'h00);
        send_q(1'b0);
        chk1("cs00_err", err, 1'b1);
        chk1("cs00_done", done, 1'b0);
        chk1("cs00_cpu_rst", cpu_rst, 1'b1);
        $display("session cs00: done=%0b err=%0b", done, err);

        // Checksum off by one bit.
        expect_wr(32'h0, 32'h2008_0005);
        expect_wr(32'h4, 32'h2009_000A);
        pulse_start();
        push_stream(8'h0F);
        send_q(1'b0);
        chk1("cs0f_err", err, 1'b1);
        $display("session cs0f: done=%0b err=%0b", done, err);

        // Zero length is rejected after the second byte.
        pulse_start();
        stim_q = '{8'h00, 8'h00};
        send_q(1'b0);
        chk1("len0_err", err, 1'b1);
        chk1("len0_busy", busy, 1'b0);
        chk1("len0_ready", byte_ready, 1'b0);
        $display("session len0: err=%0b", err);

        // MAX_WORDS+1 is rejected.
        pulse_start();
        stim_q = '{8'h01, 8'h01};
        send_q(1'b0);
        chk1("len257_err", err, 1'b1);
        chk1("len257_cpu_rst", cpu_rst, 1'b1);
        $display("session len257: err=%0b", err);

        // Single word: XOR of DE AD BE EF is 0x22.
        expect_wr(32'h0, 32'hDEAD_BEEF);
        pulse_start();
        stim_q = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
        send_q(1'b0);
        chk1("len1_done", done, 1'b1);
        $display("session len1: done=%0b", done);

        // Exactly MAX_WORDS words.
        pulse_start();
        stim_q = '{8'h01, 8'h00};
        cs = 8'h00;
        for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            w = {b, 8'h5A, ~b, 8'hC3};
            expect_wr(32'(i) * 32'd4, w);
            for (int k = 3; k >= 0; k--) begin
                stim_q.push_back(w[8*k +: 8]);
                cs = cs ^ w[8*k +: 8];
            end
        end
        stim_q.push_back(cs);
        send_q(1'b0);
        chk1("len256_done", done, 1'b1);
        chk("len256_last_addr", mem_addr, 32'h0000_03FC);
        $display("session len256: done=%0b last_addr=0x%08h", done, mem_addr);

        // Randomly gapped byte_valid.
        expect_wr(32'h0, 32'h2008_0005);
        expect_wr(32'h4, 32'h2009_000A);
        pulse_start();
        push_stream(8'h0E);
        send_q(1'b1);
        chk1("gaps_done", done, 1'b1);
        chk1("gaps_cpu_rst", cpu_rst, 1'b0);
        $display("session gaps: done=%0b", done);

        // Reset after 5 payload bytes; first word already written.
        expect_wr(32'h0, 32'h2008_0005);
        pulse_start();
        push_stream(8'h0E);
        repeat (4) void'(stim_q.pop_back());
        send_q(1'b0);
        rst = 1'b1;
        #1;
        chk1("abort_cpu_rst", cpu_rst, 1'b1);
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_ready", byte_ready, 1'b0);
        chk("abort_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        rst        = 1'b0;
        byte_valid = 1'b1;
        byte_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk1("abort_no_session", busy, 1'b0);
        byte_valid = 1'b0;
        $display("session abort: busy=%0b cpu_rst=%0b", busy, cpu_rst);
        expect_wr(32'h0, 32'h2008_0005);
        expect_wr(32'h4, 32'h2009_000A);
        pulse_start();
        push_stream(8'h0E);
        send_q(1'b0);
        chk1("reload_done", done, 1'b1);
        $display("session reload: done=%0b", done);

        // start during DATA is ignored.
        expect_wr(32'h0, 32'h2008_0005);
        expect_wr(32'h4, 32'h2009_000A);
        pulse_start();
        push_stream(8'h0E);
        hold_q.delete();
        while (stim_q.size() > 4) hold_q.push_front(stim_q.pop_back());
        send_q(1'b0);
        pulse_start();
        stim_q = hold_q;
        send_q(1'b0);
        chk1("start_in_data_done", done, 1'b1);
        $display("session start_in_data: done=%0b", done);

        // start in DONE begins a new session on the next cycle.
        pulse_start();
        chk1("restart_cpu_rst", cpu_rst, 1'b1);
        chk1("restart_done", done, 1'b0);
        chk1("restart_busy", busy, 1'b1);
        $display("session restart: cpu_rst=%0b done=%0b busy=%0b", cpu_rst, done, busy);

        repeat (2) @(negedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
